normalize_round_unit: RTL and testbench
=======================================

Name: normalize_round_unit

Overview:
- Datapath responder to the adder Control FSM.
- Registers the raw significand sum and exponent, then reports leading-one status (FFOValid/FFOIndex) and the post-round significand (Out) back to Control.
- Executes Control's per-cycle normalize/round commands (SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount, SelExpMuxR, SelManMuxR).
- Sits between the right-shift/add stage and result packing.

Parameters:
- EXPBITS, 8, exponent width.
- MANTISSABITS, 23, stored fraction width; significand register is MANTISSABITS+2 bits (carry, hidden, fraction).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  reset.
- Load  in  1  capture SumIn/ExpIn/GRSIn.
- SumIn  in  MANTISSABITS+2  raw sum {carry,hidden,fraction}.
- ExpIn  in  EXPBITS  larger operand exponent.
- GRSIn  in  3  guard, round, sticky from alignment.
- SREn, SLEn, NoShift, IncrEn, DecrEn  in  1 each  Control commands.
- ShiftAmount  in  $clog2(MANTISSABITS)  left-shift distance.
- SelExpMuxR, SelManMuxR  in  1 each  post-round renormalize select.
- FFOValid  out  1  significand register nonzero.
- FFOIndex  out  $clog2(MANTISSABITS)  index of highest set bit (0..24).
- Out  out  MANTISSABITS+2  significand register.
- ExpOut  out  EXPBITS  exponent register.
- Done  out  1  result normalized and final.
- Overflow, Underflow  out  1 each  sticky status.

Behaviour:
- Clocking: one clock, Clock. Reset is synchronous, active-high, named Reset.
- Reset values: Out=0, ExpOut=0, GRS=0, Done=0, Overflow=0, Underflow=0, state EMPTY.
- FFOValid/FFOIndex are combinational from the Out register. They are valid the cycle after Load. When Out=0, FFOIndex=0.
- State EMPTY:
  - Load -> register inputs; clear Done and flags; go to HOLD.
  - Commands are ignored.
- State HOLD/ADJUST: one command is executed per cycle. Priority order:
  1. ROUND: SelManMuxR && SelExpMuxR. Shift right by 1, exp+1, no rounding. The shifted-out bit is guaranteed 0.
  2. SREn: shift right by 1. Old LSB goes to G, G goes to R, R|S goes to S. IncrEn adds 1 to exp.
  3. SLEn: shift left by ShiftAmount, filling with G, then R, then zeros; S is kept. DecrEn subtracts ShiftAmount from exp.
  4. NoShift: no shift.
  5. No command: hold all registers.
- Rounding after SREn/SLEn/NoShift (mode per optional feature):
  - Round up when G && (R||S||Out[0]).
  - Clear GRS afterwards.
- Next state after a command:
  - Out[MANTISSABITS+1]==0 -> DONE.
  - Otherwise stay in ADJUST, waiting for ROUND.
  - This mirrors Control's SR/SL/NOSHIFT -> IDLE/ROUND decision on the same Out bit.
- DecrEn without SLEn decrements the exponent by 1.
- Exponent arithmetic is done at EXPBITS+1 bits:
  - Result >= all-ones: ExpOut = all-ones, Out = hidden bit only (infinity), Overflow=1, go to DONE.
  - Result <= 0 from a decrement: Out=0, ExpOut=0, Underflow=1, go to DONE.
- Zero sum (FFOValid=0) with NoShift: ExpOut forced to 0, Done.
- State DONE:
  - Done=1, registers held.
  - Load -> HOLD, and Done drops the next cycle.
- Load in any state takes priority over a same-cycle command and restarts the operation.
- Reset in mid-operation wins over everything.
- Overflow/Underflow are sticky until the next Load or Reset.

Optional Feature:
- Macro: NORM_ROUND_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation.
  - GRS is discarded, no increment.
  - ADJUST is entered only via SREn carry, never via rounding.
  - The ROUND command is then a no-op except exp+1 if issued.

Test Plan:
- Load SumIn=25'h0800000, ExpIn=127, GRS=0; NoShift -> FFOIndex=23, Out=25'h0800000, ExpOut=127, Done=1 the next cycle.
- Load SumIn=25'h1800000, ExpIn=127; SREn+IncrEn -> Out=25'h0C00000, ExpOut=128, GRS=000, Done=1.
- Load SumIn=25'h0010000, ExpIn=127; FFOIndex=16; SLEn+DecrEn with ShiftAmount=7 -> Out=25'h0800000, ExpOut=120.
- (RNE) Load SumIn=25'h0FFFFFF, GRS=3'b100; NoShift -> Out=25'h1000000, Done=0; then ROUND -> Out=25'h0800000, ExpOut=ExpIn+1, Done=1.
- Load ExpIn=254, SumIn=25'h1000000; SREn+IncrEn -> ExpOut=255, Out=25'h0800000, Overflow=1; next Load -> Overflow=0.
- Load SumIn=0 -> FFOValid=0; NoShift -> ExpOut=0, Done=1. Assert Reset mid-ADJUST -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/normalize_round_unit.sv
// normalize_round_unit: normalize/round datapath driven by adder Control; optional RNE rounding via NORM_ROUND_RNE_EN (truncation when undefined)
module normalize_round_unit #(
  parameter int EXPBITS = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Load,
  input  logic [MANTISSABITS+1:0]         SumIn,
  input  logic [EXPBITS-1:0]              ExpIn,
  input  logic [2:0]                      GRSIn,
  input  logic                            SREn,
  input  logic                            SLEn,
  input  logic                            NoShift,
  input  logic                            IncrEn,
  input  logic                            DecrEn,
  input  logic [$clog2(MANTISSABITS)-1:0] ShiftAmount,
  input  logic                            SelExpMuxR,
  input  logic                            SelManMuxR,
  output logic                            FFOValid,
  output logic [$clog2(MANTISSABITS)-1:0] FFOIndex,
  output logic [MANTISSABITS+1:0]         Out,
  output logic [EXPBITS-1:0]              ExpOut,
  output logic                            Done,
  output logic                            Overflow,
  output logic                            Underflow
);
  localparam int W = MANTISSABITS + 2;
  localparam int SW = $clog2(MANTISSABITS);
`ifdef NORM_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  typedef enum logic [1:0] {EMPTY, HOLD, ADJUST, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] man, man_nxt, sh_man, rnd_man;
  logic [EXPBITS-1:0] exp_r, exp_nxt;
  logic [2:0] grs, grs_nxt, sh_grs;
  logic ovf, ovf_nxt, unf, unf_nxt;
  logic [2*W+1:0] sl_ext;
  logic [EXPBITS:0] exp_sum, decv;
  logic active, cmd_round, cmd, sel_zero, rup, incv, exp_udf, exp_ovf;
  assign Out = man;
  assign ExpOut = exp_r;
  assign Overflow = ovf;
  assign Underflow = unf;
  assign FFOValid = |man;
  // leading-one index of the significand register, 0 when empty
  always_comb begin
    FFOIndex = '0;
    for (int i = 0; i < W; i++) if (man[i]) FFOIndex = SW'(i);
  end
  assign active = (state == HOLD) || (state == ADJUST);
  assign cmd_round = SelManMuxR && SelExpMuxR;
  assign cmd = cmd_round || SREn || SLEn || NoShift;
  assign sel_zero = !cmd_round && !SREn && !SLEn && NoShift && !FFOValid;
  // left shift pulls G then R then zeros into the LSBs
  assign sl_ext = {man, grs[2:1], {W{1'b0}}} << ShiftAmount;
  assign sh_man = SREn ? man >> 1 : SLEn ? sl_ext[2*W+1:W+2] : man;
  assign sh_grs = SREn ? {man[0], grs[2], grs[1] | grs[0]} : SLEn ? {sl_ext[W+1:W], grs[0]} : grs;
  assign rup = RNE && sh_grs[2] && (sh_grs[1] || sh_grs[0] || sh_man[0]);
  assign rnd_man = sh_man + {{(W-1){1'b0}}, rup};
  // exponent adjust is evaluated one bit wider so range faults are visible
  assign incv = cmd_round || (SREn && IncrEn);
  assign decv = cmd_round || !DecrEn ? '0 : SREn ? (EXPBITS+1)'(1) : SLEn ? (EXPBITS+1)'(ShiftAmount) : (EXPBITS+1)'(1);
  assign exp_sum = {1'b0, exp_r} + {{EXPBITS{1'b0}}, incv} - decv;
  assign exp_udf = (decv != '0) && (decv >= {1'b0, exp_r});
  assign exp_ovf = !exp_udf && (exp_sum >= {1'b0, {EXPBITS{1'b1}}});
  // datapath next values for load, one command, or range faults
  always_comb begin
    man_nxt = man;
    exp_nxt = exp_r;
    grs_nxt = grs;
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (Load) begin
      man_nxt = SumIn;
      exp_nxt = ExpIn;
      grs_nxt = GRSIn;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else if (active && cmd) begin
      man_nxt = cmd_round ? (RNE ? man >> 1 : man) : rnd_man;
      exp_nxt = exp_sum[EXPBITS-1:0];
      grs_nxt = '0;
      if (sel_zero) begin
        man_nxt = '0;
        exp_nxt = '0;
      end else if (exp_udf) begin
        man_nxt = '0;
        exp_nxt = '0;
        unf_nxt = 1'b1;
      end else if (exp_ovf) begin
        man_nxt = {2'b01, {MANTISSABITS{1'b0}}};
        exp_nxt = '1;
        ovf_nxt = 1'b1;
      end
    end
  end
  // datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      man <= '0;
      exp_r <= '0;
      grs <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      man <= man_nxt;
      exp_r <= exp_nxt;
      grs <= grs_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end
  // state register
  always_ff @(posedge Clock) begin
    if (Reset) state <= EMPTY;
    else state <= state_nxt;
  end
  // next state: a carry left in the top bit waits in ADJUST for ROUND
  always_comb begin
    state_nxt = state;
    if (Load) state_nxt = HOLD;
    else if (active && cmd) state_nxt = (cmd_round || !man_nxt[W-1]) ? DONE : ADJUST;
  end
  // outputs decoded from state
  always_comb begin
    Done = (state == DONE);
  end
endmodule

// File: tb/tb_normalize_round_unit.sv
// tb_normalize_round_unit: directed vectors with a tagged scoreboard queue checked by a separate monitor
module tb_normalize_round_unit;
  logic Clock = 1'b0;
  logic Reset, Load, SREn, SLEn, NoShift, IncrEn, DecrEn, SelExpMuxR, SelManMuxR;
  logic [24:0] SumIn, Out;
  logic [7:0] ExpIn, ExpOut;
  logic [2:0] GRSIn;
  logic [4:0] ShiftAmount, FFOIndex;
  logic FFOValid, Done, Overflow, Underflow;
  typedef struct packed {
    logic [24:0] o;
    logic [7:0] e;
    logic d;
    logic fv;
    logic [4:0] fi;
    logic ov;
    logic un;
  } res_t;
  localparam logic [5:0] C_NONE = 6'b000000, C_RND = 6'b100000, C_SR = 6'b010000, C_SL = 6'b001000;
  localparam logic [5:0] C_NS = 6'b000100, C_INC = 6'b000010, C_DEC = 6'b000001;
  res_t exp_q[$];
  int tag_q[$];
  string name_q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  normalize_round_unit dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .SumIn(SumIn), .ExpIn(ExpIn), .GRSIn(GRSIn),
    .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift), .IncrEn(IncrEn), .DecrEn(DecrEn),
    .ShiftAmount(ShiftAmount), .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR),
    .FFOValid(FFOValid), .FFOIndex(FFOIndex), .Out(Out), .ExpOut(ExpOut), .Done(Done),
    .Overflow(Overflow), .Underflow(Underflow)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  // monitor: compare the queue head when its cycle comes up
  always @(negedge Clock) begin
    res_t got;
    got = '{Out, ExpOut, Done, FFOValid, FFOIndex, Overflow, Underflow};
    while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
      compared++;
      if (tag_q[0] < cyc) begin
        mismatched++;
        $display("FAIL %s: check missed at cycle %0d", name_q[0], cyc);
      end else if (got !== exp_q[0]) begin
        mismatched++;
        $display("FAIL %s: got Out=%h Exp=%0d Done=%b FV=%b FI=%0d Ov=%b Un=%b, expected Out=%h Exp=%0d Done=%b FV=%b FI=%0d Ov=%b Un=%b",
                 name_q[0], got.o, got.e, got.d, got.fv, got.fi, got.ov, got.un,
                 exp_q[0].o, exp_q[0].e, exp_q[0].d, exp_q[0].fv, exp_q[0].fi, exp_q[0].ov, exp_q[0].un);
      end
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
      void'(name_q.pop_front());
    end
  end
  task automatic drive(input logic rst, input logic ld, input logic [24:0] s, input logic [7:0] e,
                       input logic [2:0] g, input logic [5:0] c, input logic [4:0] amt);
    Reset = rst;
    Load = ld;
    SumIn = s;
    ExpIn = e;
    GRSIn = g;
    {SelManMuxR, SREn, SLEn, NoShift, IncrEn, DecrEn} = c;
    SelExpMuxR = c[5];
    ShiftAmount = amt;
    @(posedge Clock);
    #1;
  endtask
  task automatic idle(input logic [5:0] c, input logic [4:0] amt);
    drive(1'b0, 1'b0, 25'h0, 8'd0, 3'b000, c, amt);
  endtask
  task automatic chk(input string n, input logic [24:0] o, input logic [7:0] e, input logic d,
                     input logic fv, input logic [4:0] fi, input logic ov, input logic un);
    exp_q.push_back('{o, e, d, fv, fi, ov, un});
    tag_q.push_back(cyc);
    name_q.push_back(n);
  endtask
  initial begin
    drive(1'b1, 1'b0, 25'h0, 8'd0, 3'b000, C_NONE, 5'd0);
    drive(1'b1, 1'b0, 25'h0, 8'd0, 3'b000, C_NONE, 5'd0);
    chk("reset", 25'h0, 8'd0, 0, 0, 5'd0, 0, 0);
    idle(C_NS | C_DEC, 5'd0);
    chk("empty_ignore", 25'h0, 8'd0, 0, 0, 5'd0, 0, 0);
    drive(1'b0, 1'b1, 25'h0800000, 8'd127, 3'b000, C_NONE, 5'd0);
    chk("load_basic", 25'h0800000, 8'd127, 0, 1, 5'd23, 0, 0);
    idle(C_NONE, 5'd0);
    chk("hold_idle", 25'h0800000, 8'd127, 0, 1, 5'd23, 0, 0);
    idle(C_DEC, 5'd0);
    chk("hold_decr_no_cmd", 25'h0800000, 8'd127, 0, 1, 5'd23, 0, 0);
    idle(C_NS, 5'd0);
    chk("noshift", 25'h0800000, 8'd127, 1, 1, 5'd23, 0, 0);
    idle(C_SR | C_INC, 5'd0);
    chk("done_hold", 25'h0800000, 8'd127, 1, 1, 5'd23, 0, 0);
    drive(1'b0, 1'b1, 25'h1800000, 8'd127, 3'b000, C_SR, 5'd0);
    chk("load_over_cmd", 25'h1800000, 8'd127, 0, 1, 5'd24, 0, 0);
    idle(C_SR | C_INC, 5'd0);
    chk("sr_incr", 25'h0C00000, 8'd128, 1, 1, 5'd23, 0, 0);
    drive(1'b0, 1'b1, 25'h0010000, 8'd127, 3'b000, C_NONE, 5'd0);
    chk("load_ffo16", 25'h0010000, 8'd127, 0, 1, 5'd16, 0, 0);
    idle(C_SL | C_DEC, 5'd7);
    chk("sl7_decr", 25'h0800000, 8'd120, 1, 1, 5'd23, 0, 0);
    drive(1'b0, 1'b1, 25'h0FFFFFF, 8'd127, 3'b100, C_NONE, 5'd0);
    chk("load_allones", 25'h0FFFFFF, 8'd127, 0, 1, 5'd23, 0, 0);
    idle(C_NS, 5'd0);
`ifdef NORM_ROUND_RNE_EN
    chk("rne_round_up", 25'h1000000, 8'd127, 0, 1, 5'd24, 0, 0);
    idle(C_RND, 5'd0);
    chk("rne_renorm", 25'h0800000, 8'd128, 1, 1, 5'd23, 0, 0);
`else
    chk("trunc_noshift", 25'h0FFFFFF, 8'd127, 1, 1, 5'd23, 0, 0);
`endif
    drive(1'b0, 1'b1, 25'h1000000, 8'd254, 3'b000, C_NONE, 5'd0);
    chk("load_254", 25'h1000000, 8'd254, 0, 1, 5'd24, 0, 0);
    idle(C_SR | C_INC, 5'd0);
    chk("overflow", 25'h0800000, 8'd255, 1, 1, 5'd23, 1, 0);
    drive(1'b0, 1'b1, 25'h0800000, 8'd10, 3'b000, C_NONE, 5'd0);
    chk("overflow_clear", 25'h0800000, 8'd10, 0, 1, 5'd23, 0, 0);
    idle(C_SL | C_DEC, 5'd10);
    chk("underflow", 25'h0, 8'd0, 1, 0, 5'd0, 0, 1);
    drive(1'b0, 1'b1, 25'h0, 8'd127, 3'b000, C_NONE, 5'd0);
    chk("load_zero", 25'h0, 8'd127, 0, 0, 5'd0, 0, 0);
    idle(C_NS, 5'd0);
    chk("zero_noshift", 25'h0, 8'd0, 1, 0, 5'd0, 0, 0);
    drive(1'b0, 1'b1, 25'h0800000, 8'd50, 3'b000, C_NONE, 5'd0);
    idle(C_NS | C_DEC, 5'd0);
    chk("noshift_decr1", 25'h0800000, 8'd49, 1, 1, 5'd23, 0, 0);
    drive(1'b0, 1'b1, 25'h1000000, 8'd100, 3'b000, C_NONE, 5'd0);
    idle(C_NS, 5'd0);
    chk("adjust_wait", 25'h1000000, 8'd100, 0, 1, 5'd24, 0, 0);
    idle(C_RND, 5'd0);
`ifdef NORM_ROUND_RNE_EN
    chk("round_cmd", 25'h0800000, 8'd101, 1, 1, 5'd23, 0, 0);
`else
    chk("round_cmd", 25'h1000000, 8'd101, 1, 1, 5'd24, 0, 0);
`endif
    drive(1'b0, 1'b1, 25'h0400000, 8'd127, 3'b110, C_NONE, 5'd0);
    idle(C_SL, 5'd2);
    chk("sl_fill_gr", 25'h1000003, 8'd127, 0, 1, 5'd24, 0, 0);
    drive(1'b1, 1'b1, 25'h0800000, 8'd5, 3'b000, C_SR, 5'd0);
    chk("reset_mid_adjust", 25'h0, 8'd0, 0, 0, 5'd0, 0, 0);
    idle(C_NONE, 5'd0);
    for (int i = 0; i < 10 && tag_q.size() > 0; i++) @(negedge Clock);
    if (tag_q.size() > 0) begin
      mismatched += tag_q.size();
      compared += tag_q.size();
      $display("FAIL drain: %0d checks never reached, expected 0", tag_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
